i_cache: RTL
============

Name: i_cache

Overview:
- Direct-mapped instruction cache between the IF stage and the memory controller's instruction port.
- Answers IF fetches from a local word store.
- On a miss, it requests the 32-bit word from the memory controller and holds that request until the word returns, then fills the line and answers IF.
- The memory controller owns arbitration (data port has priority), so this block only has to hold its request stable across any pre-emption.

Parameters:
INDEX_BITS, 7, log2 of line count (128 one-word lines)
ADDR_LEN, 32, address width (matches AddrLen)
INST_LEN, 32, instruction width (matches InstLen)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
if_req  in  1  one-cycle fetch request strobe from IF
if_addr  in  ADDR_LEN  fetch address, sampled with if_req; bits [1:0] ignored
if_flush  in  1  drop any outstanding fetch (branch/jump redirect)
inv_all  in  1  one-cycle strobe: clear all valid bits (fence.i)
inst_o  out  INST_LEN  fetched instruction
inst_valid  out  1  one-cycle pulse: inst_o valid for the last accepted request
mc_req  out  1  to controller icache_needed; level, held until mc_inst_valid
mc_addr  out  ADDR_LEN  to controller icache_addr; word-aligned miss address
mc_inst_i  in  INST_LEN  from controller inst_o
mc_inst_valid  in  1  from controller inst_data_enable; one-cycle pulse

Behaviour:
- Reset (rst high at posedge):
  - All valid bits cleared; state IDLE.
  - inst_o = 0, inst_valid = 0, mc_req = 0, mc_addr = 0.
  - A reset mid-miss aborts the miss; no fill, no response.
- Address split:
  - index = addr[INDEX_BITS+1:2].
  - tag = addr[ADDR_LEN-1:INDEX_BITS+2].
  - Each line stores valid, tag and a 32-bit word.
- Protocol rule: IF issues at most one outstanding request; it must not strobe if_req again before inst_valid or if_flush.
- State IDLE:
  - if_req with a hit (valid and tag equal) -> inst_o = stored word and inst_valid = 1 in the next cycle; stay IDLE. Hit latency is 1 cycle.
  - if_req with a miss -> latch mc_addr = {if_addr[31:2], 2'b00} and go to MISS; inst_valid stays 0.
- State MISS:
  - mc_req = 1 and mc_addr is held constant for the whole state.
  - if_req is ignored.
  - If the controller pre-empts for a data access, mc_req stays high; the controller restarts the 4-byte read itself.
- MISS with mc_inst_valid:
  - At that edge: write the line (valid = 1, tag, mc_inst_i), drive inst_o = mc_inst_i, pulse inst_valid = 1 next cycle, return to IDLE.
  - mc_req is decoded from state, so it is still high in the mc_inst_valid cycle. The controller may begin a redundant read, which is aborted when mc_req drops. This is expected and not an error.
- if_flush:
  - Highest priority after rst.
  - In IDLE, a coincident if_req is dropped.
  - In MISS, go to IDLE and drop mc_req next cycle.
  - If mc_inst_valid coincides with if_flush, the line is still written (the data is correct for mc_addr) but inst_valid is NOT asserted.
- inv_all:
  - Clears all valid bits at the edge.
  - If coincident with a fill, the fill's valid bit is written 0 (invalidate wins), but the response to IF is still delivered.
  - In IDLE, a coincident if_req is treated as a miss.
- inst_valid is a pulse of exactly 1 cycle. inst_o holds its value until the next response; it is not zeroed between responses.
- Fill and lookup on the same index in back-to-back cycles: the lookup sees the filled line (write at edge, lookup reads the updated array).

Decomposition:
- config.vh gets:
  - new ICacheIndexBits.
  - Existing AddrLen, InstLen, ZERO_WORD, ResetEnable.
  - State encodings IDLE = 1'b0, MISS = 1'b1.
- One sub-module: icache_store.
  - Valid/tag/data arrays with one combinational read port (index) and one synchronous write port.
  - Plus a clear-all-valid input.
  - FSM and handshake stay in i_cache.

Test Plan:
- Cold miss:
  - Stimulus: if_req, if_addr=0x00001004; controller returns mc_inst_valid with 0x00A00093 after 5 cycles.
  - Response: mc_req high with mc_addr=0x00001004 until the pulse, then inst_valid=1 and inst_o=0x00A00093.
  - Repeat fetch of 0x00001004 -> hit, inst_valid next cycle, no mc_req.
- Conflict: fill 0x00000010 and then 0x00000210 (same index, INDEX_BITS=7) -> second fetch misses; re-fetch of 0x00000010 misses again.
- Pre-emption:
  - Stimulus: during a miss, the controller services a data load for 6 cycles before instruction bytes.
  - Response: mc_req and mc_addr stable throughout; single inst_valid with the correct word.
- Flush mid-miss: if_flush 2 cycles into a miss -> mc_req 0 next cycle, no inst_valid. A flush coincident with mc_inst_valid gives no inst_valid, and a later fetch of that address hits.
- inv_all: after filling 0x0 and 0x4, pulse inv_all -> both fetches miss; a fill coincident with inv_all responds to IF but the next fetch of that address misses.
- Reset mid-miss: rst during MISS -> mc_req=0, inst_valid=0, inst_o=0 next cycle; a prior hit address now misses.

Source files
------------

// File: rtl/i_cache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
// Default geometry: 128 one-word lines, 32-bit addresses and instructions.
package i_cache_pkg;

  localparam int ICACHE_INDEX_BITS = 7;
  localparam int ICACHE_ADDR_LEN   = 32;
  localparam int ICACHE_INST_LEN   = 32;

  localparam logic [ICACHE_INST_LEN-1:0] ZERO_WORD    = '0;
  localparam bit                         RESET_ENABLE = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

endpackage

// File: rtl/i_cache_store.sv
// Line storage for i_cache: valid/tag/data arrays with a combinational read
// port, a synchronous write port and a synchronous clear of every valid bit.
module icache_store
  import i_cache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int TAG_BITS   = ICACHE_ADDR_LEN - ICACHE_INDEX_BITS - 2,
  parameter int DATA_BITS  = ICACHE_INST_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_all,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_BITS-1:0]  rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_BITS-1:0]  wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_mem  [LINES];
  logic [DATA_BITS-1:0] data_mem [LINES];

  // A clear coinciding with a fill wins, so the freshly written line is invalid.
  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are not reset; every read is qualified by valid_q,
  // which keeps them as plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/i_cache.sv
// Direct-mapped instruction cache between IF and the memory controller's
// instruction port: 1-cycle hits, a held level request on misses.
module i_cache
  import i_cache_pkg::*;
#(
  parameter int INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int ADDR_LEN   = ICACHE_ADDR_LEN,
  parameter int INST_LEN   = ICACHE_INST_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_LEN-1:0] if_addr,
  input  logic                if_flush,
  input  logic                inv_all,
  output logic [INST_LEN-1:0] inst_o,
  output logic                inst_valid,
  output logic                mc_req,
  output logic [ADDR_LEN-1:0] mc_addr,
  input  logic [INST_LEN-1:0] mc_inst_i,
  input  logic                mc_inst_valid
);

  localparam int TAG_BITS = ADDR_LEN - INDEX_BITS - 2;

  state_t state_q, state_d;

  logic [ADDR_LEN-1:0]   mc_addr_d;
  logic [INST_LEN-1:0]   inst_o_d;
  logic                  inst_valid_d;
  logic                  fill_en;

  logic [INDEX_BITS-1:0] rd_index;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [INST_LEN-1:0]   rd_data;
  logic                  hit;

  logic                  unused_addr_bits;
  assign unused_addr_bits = ^if_addr[1:0];

  assign rd_index   = if_addr[INDEX_BITS+1:2];
  assign lookup_tag = if_addr[ADDR_LEN-1:INDEX_BITS+2];

  // A coincident invalidate turns the lookup into a miss.
  assign hit = rd_valid && (rd_tag == lookup_tag) && !inv_all;

  icache_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_BITS  (INST_LEN)
  ) u_store (
    .clk      (clk),
    .rst      (rst),
    .clr_all  (inv_all),
    .rd_index (rd_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_en),
    .wr_index (mc_addr[INDEX_BITS+1:2]),
    .wr_tag   (mc_addr[ADDR_LEN-1:INDEX_BITS+2]),
    .wr_data  (mc_inst_i)
  );

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    mc_addr_d    = mc_addr;
    inst_o_d     = inst_o;
    inst_valid_d = 1'b0;
    fill_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!if_flush && if_req) begin
          if (hit) begin
            inst_valid_d = 1'b1;
            inst_o_d     = rd_data;
          end else begin
            state_d   = MISS;
            mc_addr_d = {if_addr[ADDR_LEN-1:2], 2'b00};
          end
        end
      end
      MISS: begin
        if (mc_inst_valid) begin
          // The returned word is correct for mc_addr even when IF has moved on.
          fill_en = !rst;
          state_d = IDLE;
          if (!if_flush) begin
            inst_valid_d = 1'b1;
            inst_o_d     = mc_inst_i;
          end
        end else if (if_flush) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // NOTE: state and output registers use non-blocking assignments so every
  // flop samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mc_addr    <= '0;
      inst_o     <= '0;
      inst_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      mc_addr    <= mc_addr_d;
      inst_o     <= inst_o_d;
      inst_valid <= inst_valid_d;
    end
  end

  assign mc_req = (state_q == MISS);

endmodule
